// File: rtl/wb_port_progress_monitor.sv
// rtl/wb_port_progress_monitor.sv - mprj_io firmware progress monitor: start signature, ordered result stages, fail and timeout
module wb_port_progress_monitor #(
    parameter int IO_W    = 38,
    parameter int CHK_LSB = 16,
    parameter int CHK_W   = 16,
    parameter int RES_LSB = 8,
    parameter int RES_W   = 8,
    parameter int NSTAGE  = 4,
    parameter int STABLE  = 2,
    parameter int TICK    = 1000
) (
    input  logic                        clock,
    input  logic                        resetb,
    input  logic                        enable,
    input  logic [IO_W-1:0]             mprj_io_in,
    input  logic [CHK_W-1:0]            start_pat,
    input  logic [CHK_W-1:0]            fail_pat,
    input  logic [NSTAGE*RES_W-1:0]     exp_res,
    input  logic [15:0]                 timeout_ticks,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [1:0]                  fail_code,
    output logic [$clog2(NSTAGE+1)-1:0] stage,
    output logic [15:0]                 tick_count
);
    localparam int SW = $clog2(NSTAGE + 1);
    localparam int CW = $clog2(STABLE + 1);
    localparam int PW = $clog2(TICK);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_START, S_WAIT_STAGE, S_PASS, S_FAIL, S_TIMEOUT
    } state_t;

    state_t           state, state_nxt;
    logic [CHK_W-1:0] chk_q;
    logic [RES_W-1:0] res_q;
    logic [RES_W-1:0] cur_exp;
    logic [CW-1:0]    match_cnt, match_cnt_nxt, fail_cnt, fail_cnt_nxt;
    logic [SW-1:0]    stage_q, stage_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic [15:0]      ticks, ticks_nxt;
    logic             match, match_hit, fail_hit, wrap;
    logic             unused_io;

    assign unused_io  = ^mprj_io_in;
    assign stage      = stage_q;
    assign tick_count = ticks;

    always_comb begin
        cur_exp = '0;
        for (int i = 0; i < NSTAGE; i++) begin
            if (stage_q == SW'(i)) cur_exp = exp_res[i*RES_W +: RES_W];
        end
    end

    always_comb begin
        state_nxt     = state;
        match_cnt_nxt = match_cnt;
        fail_cnt_nxt  = fail_cnt;
        stage_nxt     = stage_q;
        presc_nxt     = presc;
        ticks_nxt     = ticks;
        match         = 1'b0;
        match_hit     = 1'b0;
        fail_hit      = 1'b0;
        wrap          = 1'b0;
        case (state)
            S_IDLE: begin
                match_cnt_nxt = '0;
                fail_cnt_nxt  = '0;
                stage_nxt     = '0;
                presc_nxt     = '0;
                ticks_nxt     = '0;
                if (enable) state_nxt = S_WAIT_START;
            end
            S_WAIT_START, S_WAIT_STAGE: begin
                wrap      = (presc == PW'(TICK - 1));
                presc_nxt = wrap ? '0 : presc + PW'(1);
                if (wrap && ticks != 16'hFFFF) ticks_nxt = ticks + 16'd1;

                if (chk_q == fail_pat) begin
                    fail_cnt_nxt = fail_cnt + CW'(1);
                    fail_hit     = (fail_cnt_nxt == CW'(STABLE));
                end else begin
                    fail_cnt_nxt = '0;
                end

                match = (state == S_WAIT_START) ? (chk_q == start_pat) : (res_q == cur_exp);
                if (match) begin
                    match_cnt_nxt = match_cnt + CW'(1);
                    if (match_cnt_nxt == CW'(STABLE)) begin
                        match_hit     = 1'b1;
                        match_cnt_nxt = '0;
                    end
                end else begin
                    match_cnt_nxt = '0;
                end

                // fail beats stage/pass completion, which beats timeout
                if (fail_hit) begin
                    state_nxt = S_FAIL;
                end else if (match_hit) begin
                    if (state == S_WAIT_START) begin
                        state_nxt = S_WAIT_STAGE;
                        stage_nxt = '0;
                    end else begin
                        stage_nxt = stage_q + SW'(1);
                        if (stage_nxt == SW'(NSTAGE)) state_nxt = S_PASS;
                    end
                end else if (timeout_ticks != 16'd0 && ticks_nxt >= timeout_ticks) begin
                    state_nxt = S_TIMEOUT;
                end
            end
            default: ;
        endcase
        if (!enable) begin
            state_nxt     = S_IDLE;
            match_cnt_nxt = '0;
            fail_cnt_nxt  = '0;
            stage_nxt     = '0;
            presc_nxt     = '0;
            ticks_nxt     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state     <= S_IDLE;
            chk_q     <= '0;
            res_q     <= '0;
            match_cnt <= '0;
            fail_cnt  <= '0;
            stage_q   <= '0;
            presc     <= '0;
            ticks     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_code <= 2'd0;
        end else begin
            state     <= state_nxt;
            chk_q     <= mprj_io_in[CHK_LSB +: CHK_W];
            res_q     <= mprj_io_in[RES_LSB +: RES_W];
            match_cnt <= match_cnt_nxt;
            fail_cnt  <= fail_cnt_nxt;
            stage_q   <= stage_nxt;
            presc     <= presc_nxt;
            ticks     <= ticks_nxt;
            busy      <= (state_nxt == S_WAIT_START) || (state_nxt == S_WAIT_STAGE);
            done      <= (state_nxt == S_PASS) || (state_nxt == S_FAIL) || (state_nxt == S_TIMEOUT);
            pass      <= (state_nxt == S_PASS);
            fail_code <= (state_nxt == S_FAIL) ? 2'd1 : (state_nxt == S_TIMEOUT) ? 2'd2 : 2'd0;
        end
    end
endmodule

// File: tb/tb_wb_port_progress_monitor.sv
// tb/tb_wb_port_progress_monitor.sv - directed self-checking bench for wb_port_progress_monitor
module tb_wb_port_progress_monitor;
    logic        clock = 1'b0;
    logic        resetb;
    logic        enable;
    logic [37:0] mprj_io_in;
    logic [15:0] start_pat, fail_pat;
    logic [15:0] exp_res;
    logic [15:0] timeout_ticks;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [1:0]  stage;
    logic [15:0] tick_count;

    int total = 0;
    int bad   = 0;

    wb_port_progress_monitor #(
        .IO_W(38), .CHK_LSB(16), .CHK_W(16), .RES_LSB(8), .RES_W(8),
        .NSTAGE(2), .STABLE(2), .TICK(10)
    ) dut (
        .clock(clock), .resetb(resetb), .enable(enable), .mprj_io_in(mprj_io_in),
        .start_pat(start_pat), .fail_pat(fail_pat), .exp_res(exp_res),
        .timeout_ticks(timeout_ticks), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .stage(stage), .tick_count(tick_count)
    );

    always #5 clock = ~clock;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [15:0] chk, input logic [7:0] res, input int n);
        mprj_io_in = {6'b0, chk, res, 8'h00};
        step(n);
    endtask

    task automatic start_run();
        enable = 1'b1;
        drive(16'h0, 8'h0, 1);
    endtask

    task automatic go_idle();
        enable = 1'b0;
        drive(16'h0, 8'h0, 1);
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        enable = 1'b0;
        drive(16'h0, 8'h0, 2);
        total++;
        if ({busy, done, pass, fail_code, stage, tick_count} !== 23'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%0h exp=0", {busy, done, pass, fail_code, stage, tick_count});
        end
        resetb = 1'b1;
        step(2);
        total++;
        if ({busy, done, pass, fail_code, stage, tick_count} !== 23'd0) begin
            bad++;
            $display("FAIL idle_disabled got=%0h exp=0", {busy, done, pass, fail_code, stage, tick_count});
        end
    endtask

    task automatic test_pass();
        timeout_ticks = 16'd0;
        start_run();
        drive(16'hAB60, 8'h00, 3);
        total++;
        if ({busy, done, stage} !== 4'b1000) begin
            bad++;
            $display("FAIL pass_after_start got=%b exp=1000", {busy, done, stage});
        end
        drive(16'h0, 8'h12, 3);
        total++;
        if ({busy, done, stage} !== 4'b1001) begin
            bad++;
            $display("FAIL pass_stage1 got=%b exp=1001", {busy, done, stage});
        end
        drive(16'h0, 8'h34, 3);
        total++;
        if ({busy, done, pass, fail_code, stage} !== 7'b0110010) begin
            bad++;
            $display("FAIL pass_final got=%b exp=0110010", {busy, done, pass, fail_code, stage});
        end
        drive(16'h0, 8'h00, 5);
        total++;
        if ({done, pass, stage} !== 4'b1110) begin
            bad++;
            $display("FAIL pass_sticky got=%b exp=1110", {done, pass, stage});
        end
        go_idle();
        total++;
        if ({busy, done, pass, fail_code, stage, tick_count} !== 23'd0) begin
            bad++;
            $display("FAIL pass_to_idle got=%0h exp=0", {busy, done, pass, fail_code, stage, tick_count});
        end
    endtask

    task automatic test_glitch();
        start_run();
        drive(16'hAB60, 8'h00, 1);
        drive(16'h0, 8'h00, 4);
        total++;
        if ({busy, done, stage} !== 4'b1000) begin
            bad++;
            $display("FAIL glitch_start got=%b exp=1000", {busy, done, stage});
        end
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h00, 1);
        total++;
        if ({busy, done, stage} !== 4'b1000) begin
            bad++;
            $display("FAIL result_before_start got=%b exp=1000", {busy, done, stage});
        end
        go_idle();
    endtask

    task automatic test_fail();
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'hAB6F, 8'h00, 2);
        drive(16'h0, 8'h00, 1);
        total++;
        if ({busy, done, pass, fail_code, stage} !== 7'b0100101) begin
            bad++;
            $display("FAIL fail_pattern got=%b exp=0100101", {busy, done, pass, fail_code, stage});
        end
        drive(16'h0, 8'h34, 5);
        total++;
        if ({done, fail_code, stage} !== 5'b10101) begin
            bad++;
            $display("FAIL fail_sticky got=%b exp=10101", {done, fail_code, stage});
        end
        go_idle();
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'hAB6F, 8'h34, 3);
        total++;
        if ({pass, fail_code, stage} !== 5'b00101) begin
            bad++;
            $display("FAIL fail_beats_pass got=%b exp=00101", {pass, fail_code, stage});
        end
        go_idle();
    endtask

    task automatic test_timeout();
        int n;
        timeout_ticks = 16'd5;
        enable = 1'b1;
        mprj_io_in = '0;
        n = 0;
        do begin
            step(1);
            n++;
        end while (!done && n < 200);
        total++;
        if (n < 50 || n > 52) begin
            bad++;
            $display("FAIL timeout_latency got=%0d exp=51(+-1)", n);
        end
        total++;
        if ({busy, pass, fail_code, tick_count} !== {2'b00, 2'd2, 16'd5}) begin
            bad++;
            $display("FAIL timeout_state got=%0h exp=%0h", {busy, pass, fail_code, tick_count}, {2'b00, 2'd2, 16'd5});
        end
        step(20);
        total++;
        if (tick_count !== 16'd5) begin
            bad++;
            $display("FAIL timeout_frozen got=%0d exp=5", tick_count);
        end
        go_idle();
        timeout_ticks = 16'd0;
        start_run();
        step(2000);
        total++;
        if ({busy, done, tick_count} !== {2'b10, 16'd200}) begin
            bad++;
            $display("FAIL no_timeout got=%0h exp=%0h", {busy, done, tick_count}, {2'b10, 16'd200});
        end
        go_idle();
    endtask

    task automatic test_pass_at_timeout();
        timeout_ticks = 16'd1;
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h00, 1);
        drive(16'h0, 8'h34, 3);
        total++;
        if ({pass, fail_code, stage} !== 5'b10010) begin
            bad++;
            $display("FAIL pass_beats_timeout got=%b exp=10010", {pass, fail_code, stage});
        end
        go_idle();
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h00, 2);
        drive(16'h0, 8'h34, 3);
        total++;
        if ({pass, fail_code, stage} !== 5'b01001) begin
            bad++;
            $display("FAIL timeout_before_pass got=%b exp=01001", {pass, fail_code, stage});
        end
        go_idle();
        timeout_ticks = 16'd0;
    endtask

    task automatic test_enable_drop();
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h00, 20);
        total++;
        if ({busy, stage, tick_count} !== {1'b1, 2'd1, 16'd2}) begin
            bad++;
            $display("FAIL mid_run got=%0h exp=%0h", {busy, stage, tick_count}, {1'b1, 2'd1, 16'd2});
        end
        go_idle();
        total++;
        if ({busy, done, pass, fail_code, stage, tick_count} !== 23'd0) begin
            bad++;
            $display("FAIL abort_idle got=%0h exp=0", {busy, done, pass, fail_code, stage, tick_count});
        end
        start_run();
        total++;
        if ({busy, done, stage, tick_count} !== {2'b10, 2'd0, 16'd0}) begin
            bad++;
            $display("FAIL restart got=%0h exp=%0h", {busy, done, stage, tick_count}, {2'b10, 2'd0, 16'd0});
        end
        go_idle();
    endtask

    task automatic test_reset_in_pass();
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h34, 3);
        total++;
        if (pass !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_pass got=%b exp=1", pass);
        end
        resetb = 1'b0;
        drive(16'h0, 8'h00, 1);
        total++;
        if ({busy, done, pass, fail_code, stage, tick_count} !== 23'd0) begin
            bad++;
            $display("FAIL reset_in_pass got=%0h exp=0", {busy, done, pass, fail_code, stage, tick_count});
        end
        resetb = 1'b1;
        start_run();
        drive(16'hAB60, 8'h00, 3);
        drive(16'h0, 8'h12, 3);
        drive(16'h0, 8'h34, 3);
        total++;
        if ({pass, done, fail_code, stage} !== 6'b110010) begin
            bad++;
            $display("FAIL rerun_after_reset got=%b exp=110010", {pass, done, fail_code, stage});
        end
        go_idle();
    endtask

    initial begin
        resetb        = 1'b0;
        enable        = 1'b0;
        mprj_io_in    = '0;
        start_pat     = 16'hAB60;
        fail_pat      = 16'hAB6F;
        exp_res       = {8'h34, 8'h12};
        timeout_ticks = 16'd0;
        test_reset();
        test_pass();
        test_glitch();
        test_fail();
        test_timeout();
        test_pass_at_timeout();
        test_enable_drop();
        test_reset_in_pass();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_port_progress_monitor.md
Name: wb_port_progress_monitor

Overview:
- Synthesizable, parametrised successor to the wb_port firmware-progress check: watches a checkpoint field and a result field of the mprj_io bus.
- Detects a start signature, then an ordered sequence of NSTAGE expected result values, and flags pass, explicit fail or timeout.
- Sits beside the user project as an on-chip self-test monitor; the same RTL is reused in DV benches as a reusable checker.

Parameters:
IO_W, 38, width of monitored mprj_io bus
CHK_LSB, 16, LSB of checkpoint field
CHK_W, 16, checkpoint field width
RES_LSB, 8, LSB of result field
RES_W, 8, result field width
NSTAGE, 4, number of ordered result stages (>=1)
STABLE, 2, consecutive cycles a match must hold (>=1)
TICK, 1000, clock cycles per timeout tick (>=2)

Ports:
clock  in  1  single clock, all logic on rising edge
resetb  in  1  synchronous active-low reset
enable  in  1  run monitor; low returns to IDLE
mprj_io_in  in  IO_W  monitored pad bus
start_pat  in  CHK_W  checkpoint value signalling start
fail_pat  in  CHK_W  checkpoint value signalling firmware failure
exp_res  in  NSTAGE*RES_W  stage i expected result at [i*RES_W +: RES_W]
timeout_ticks  in  16  timeout in ticks; 0 disables timeout
busy  out  1  high in WAIT_START/WAIT_STAGE
done  out  1  high in PASS/FAIL/TIMEOUT
pass  out  1  high in PASS
fail_code  out  2  0 none, 1 fail pattern, 2 timeout
stage  out  $clog2(NSTAGE+1)  stages completed so far
tick_count  out  16  elapsed ticks since enable

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports named clock and resetb.
- Reset (resetb=0 at clock edge): state=IDLE, all outputs 0, all counters 0.
- chk = mprj_io_in[CHK_LSB +: CHK_W]; res = mprj_io_in[RES_LSB +: RES_W]; fields sampled into a register (1-cycle input latency).
- States: IDLE, WAIT_START, WAIT_STAGE, PASS, FAIL, TIMEOUT.
- IDLE: enable=1 -> WAIT_START; prescaler, tick_count, stage, stable counter cleared.
- WAIT_START: chk==start_pat held STABLE consecutive sampled cycles -> WAIT_STAGE, stage=0.
- WAIT_STAGE: res==exp_res[stage] held STABLE cycles -> stage+1. If new stage==NSTAGE -> PASS, else stay.
- Stable counter clears on any mismatch and on every state or stage advance. A value matching two consecutive stages therefore needs 2*STABLE cycles.
- Fail: in WAIT_START or WAIT_STAGE, chk==fail_pat for STABLE cycles -> FAIL, fail_code=1. Not checked in IDLE. If start_pat==fail_pat, fail wins.
- Timeout: prescaler counts 0..TICK-1 while busy. On wrap, tick_count increments, saturating at 16'hFFFF. When tick_count reaches timeout_ticks (nonzero) while busy -> TIMEOUT, fail_code=2.
- Same-cycle priority: fail > stage/pass completion > timeout.
- PASS/FAIL/TIMEOUT are sticky: outputs and tick_count frozen until enable=0 (-> IDLE next cycle, outputs cleared) or reset.
- enable=0 in any state -> IDLE next edge, aborting the run. Reset mid-run behaves identically to power-on reset.
- exp_res, start_pat, fail_pat and timeout_ticks may change at runtime; they are used combinationally on the current stage. No latching.
- Outputs are registered and decoded from state: busy, done, pass and fail_code are mutually consistent every cycle.

Test Plan:
- NSTAGE=2, STABLE=2, TICK=10, exp_res={8'h34,8'h12}, start_pat=16'hAB60. Drive chk=AB60 3 cycles, then res=12 3 cycles, then res=34 3 cycles -> stage 0->1->2; pass=1, done=1, fail_code=0.
- Same setup, chk=AB60 for 1 cycle only (glitch) -> remains WAIT_START, busy=1. Then res=12 before start -> stage stays 0.
- fail_pat=16'hAB6F driven for 2 cycles after stage 1 -> FAIL, fail_code=1, stage=1 frozen. Fail and last-stage match in the same cycle -> FAIL.
- timeout_ticks=5, TICK=10, no start -> TIMEOUT exactly 50 cycles after entering WAIT_START (+-1 for input register), tick_count=5. timeout_ticks=0 -> never times out in 2000 cycles.
- Final stage match on the same cycle as timeout expiry -> PASS. enable dropped in WAIT_STAGE -> IDLE, outputs 0. Re-enable restarts at stage 0, tick_count 0.
- resetb=0 for 1 cycle while in PASS -> all outputs 0 next edge, state IDLE, even with enable held high. Re-run completes normally.
